regfile_write_sched: RTL and testbench

Write-port scheduler for the 32-entry register file. It owns the file's single write port (`regToWrite`, `write_data`, `doRegWrite`) and shares it between two writeback requesters, the ALU path and the load path, using valid/ready handshakes and round-robin arbitration. After every reset it sequences an initialisation sweep that writes zero to every register, because the register file itself does not clear its storage on reset. It sits between the writeback stage and the register file.

---
 rtl/regfile_write_sched.sv | 132 +++++++++++++
 tb/tb_regfile_write_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: owns the register file write port and shares it round-robin between ALU and load writeback.
// Define RF_INIT_SWEEP_EN to zero every register after reset before any request is granted.
module regfile_write_sched #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int WORD_BITWIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] req0_reg,
    input  logic [WORD_BITWIDTH-1:0]    req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [REG_NUM_BITWIDTH-1:0] req1_reg,
    input  logic [WORD_BITWIDTH-1:0]    req1_data,
    output logic                        req1_ready,
    output logic                        init_busy,
    output logic [REG_NUM_BITWIDTH-1:0] regToWrite,
    output logic [WORD_BITWIDTH-1:0]    write_data,
    output logic                        doRegWrite
);

    logic                        sweepActive;
    logic [REG_NUM_BITWIDTH-1:0] sweepIdx;
    logic                        grant0;
    logic                        grant1;
    logic                        lastGrant_q, lastGrant_d;
    logic                        doRegWrite_q, doRegWrite_d;
    logic [REG_NUM_BITWIDTH-1:0] regToWrite_q, regToWrite_d;
    logic [WORD_BITWIDTH-1:0]    writeData_q, writeData_d;

`ifdef RF_INIT_SWEEP_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [REG_NUM_BITWIDTH-1:0] CNT_ONE = REG_NUM_BITWIDTH'(1);

    state_t                      state_q, state_d;
    logic [REG_NUM_BITWIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep leaves INIT on the same edge that issues the last register index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    assign sweepActive = (state_q == ST_INIT);
    assign sweepIdx    = cnt_q;
    assign init_busy   = rst | sweepActive;
`else
    assign sweepActive = 1'b0;
    assign sweepIdx    = '0;
    assign init_busy   = 1'b0;
`endif

    // Ready depends only on valids, state, reset and last winner, never on register index or data.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!sweepActive && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = lastGrant_q;
                grant1 = ~lastGrant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        doRegWrite_d = 1'b0;
        regToWrite_d = regToWrite_q;
        writeData_d  = writeData_q;
        lastGrant_d  = lastGrant_q;
        if (sweepActive) begin
            doRegWrite_d = 1'b1;
            regToWrite_d = sweepIdx;
            writeData_d  = '0;
        end else if (grant0) begin
            doRegWrite_d = |req0_reg;
            regToWrite_d = req0_reg;
            writeData_d  = req0_data;
            lastGrant_d  = 1'b0;
        end else if (grant1) begin
            doRegWrite_d = |req1_reg;
            regToWrite_d = req1_reg;
            writeData_d  = req1_data;
            lastGrant_d  = 1'b1;
        end
    end

    // lastGrant resets to 1 so requester 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            doRegWrite_q <= 1'b0;
            regToWrite_q <= '0;
            writeData_q  <= '0;
            lastGrant_q  <= 1'b1;
        end else begin
            doRegWrite_q <= doRegWrite_d;
            regToWrite_q <= regToWrite_d;
            writeData_q  <= writeData_d;
            lastGrant_q  <= lastGrant_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign doRegWrite = doRegWrite_q;
    assign regToWrite = regToWrite_q;
    assign write_data = writeData_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb_regfile_write_sched: directed checks of reset, sweep (when RF_INIT_SWEEP_EN is defined), grants and write issue.
module tb_regfile_write_sched;

`ifdef RF_INIT_SWEEP_EN
    localparam logic SWEEP = 1'b1;
`else
    localparam logic SWEEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_reg;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_reg;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        init_busy;
    logic [4:0]  regToWrite;
    logic [31:0] write_data;
    logic        doRegWrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_sched #(
        .REG_NUM_BITWIDTH(5),
        .WORD_BITWIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_reg(req0_reg),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg(req1_reg),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .init_busy(init_busy),
        .regToWrite(regToWrite),
        .write_data(write_data),
        .doRegWrite(doRegWrite)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        req0_valid = v0;
        req0_reg   = r0;
        req0_data  = d0;
        req1_valid = v1;
        req1_reg   = r1;
        req1_data  = d1;
    endtask

    task automatic checkWrite(input string tag, input logic expWe, input logic [4:0] expReg, input logic [31:0] expData);
        @(posedge clk);
        #1;
        checkOutput({tag, "_we"}, doRegWrite, expWe);
        checkOutput({tag, "_reg"}, regToWrite, expReg);
        checkOutput({tag, "_data"}, write_data, expData);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", doRegWrite, 1'b0);
        checkOutput("rst_reg", regToWrite, 5'd0);
        checkOutput("rst_data", write_data, 32'h0);
        checkOutput("rst_ready0", req0_ready, 1'b0);
        checkOutput("rst_busy", init_busy, SWEEP);

        @(negedge clk);
        rst = 1'b0;
`ifdef RF_INIT_SWEEP_EN
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        for (int i = 0; i < 32; i++) begin
            #1;
            checkOutput("sweep_ready0", req0_ready, 1'b0);
            checkOutput("sweep_ready1", req1_ready, 1'b0);
            checkOutput("sweep_busy", init_busy, 1'b1);
            checkWrite("sweep", 1'b1, i[4:0], 32'h0);
            @(negedge clk);
        end
        checkOutput("sweep_done_busy", init_busy, 1'b0);
`endif

        // First grant: requester 0 alone, right after reset or sweep.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("single_ready0", req0_ready, 1'b1);
        checkOutput("single_ready1", req1_ready, 1'b0);
        checkOutput("single_busy", init_busy, 1'b0);
        checkWrite("single", 1'b1, 5'd5, 32'hDEAD_BEEF);

        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        #1;
        checkOutput("x0_ready1", req1_ready, 1'b1);
        checkOutput("x0_ready0", req0_ready, 1'b0);
        checkWrite("x0", 1'b0, 5'd0, 32'h1234);

        @(negedge clk);
        applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("cont_ready0", req0_ready, (k % 2) == 0);
            checkOutput("cont_ready1", req1_ready, (k % 2) == 1);
            if ((k % 2) == 0) begin
                checkWrite("cont", 1'b1, 5'd1, 32'hA1);
            end else begin
                checkWrite("cont", 1'b1, 5'd2, 32'hB2);
            end
            @(negedge clk);
        end

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("idle_ready0", req0_ready, 1'b0);
        checkOutput("idle_ready1", req1_ready, 1'b0);
        checkWrite("idle", 1'b0, 5'd2, 32'hB2);

        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55);
        #1;
        checkOutput("solo1_ready1", req1_ready, 1'b1);
        checkWrite("solo1", 1'b1, 5'd9, 32'h55);

        @(negedge clk);
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready0", req0_ready, 1'b0);
        checkOutput("midrst_ready1", req1_ready, 1'b0);
        checkOutput("midrst_busy", init_busy, SWEEP);
        checkWrite("midrst", 1'b0, 5'd0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef RF_INIT_SWEEP_EN
        checkOutput("resweep_ready0", req0_ready, 1'b0);
        checkOutput("resweep_busy", init_busy, 1'b1);
        checkWrite("resweep0", 1'b1, 5'd0, 32'h0);
        checkWrite("resweep1", 1'b1, 5'd1, 32'h0);
`else
        checkOutput("postrst_ready0", req0_ready, 1'b1);
        checkOutput("postrst_ready1", req1_ready, 1'b0);
        checkOutput("postrst_busy", init_busy, 1'b0);
        checkWrite("postrst", 1'b1, 5'd3, 32'h33);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
